// File: rtl/fc_tcdm_pkg.sv
// Shared types and helpers for the FC-side TCDM adapters.
package fc_tcdm_pkg;

    localparam int unsigned TcdmAddrWidth = 32;
    localparam int unsigned TcdmDataWidth = 32;
    localparam int unsigned MaxPortIdxW   = 8;

    // Index width for n ports; at least one bit so a degenerate count still has a legal vector.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [MaxPortIdxW-1:0] port_idx_t;

    typedef struct packed {
        logic [TcdmAddrWidth-1:0]   add;
        logic                       wen;
        logic [TcdmDataWidth/8-1:0] be;
        logic [TcdmDataWidth-1:0]   wdata;
    } tcdm_req_t;

endpackage

// File: rtl/fc_tcdm_idx_fifo.sv
// Small FIFO of port indices with fall-through head; remembers which port owns each
// outstanding transaction so responses can be routed back in order.
module fc_tcdm_idx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    import fc_tcdm_pkg::*;

    localparam int unsigned PtrW = idx_w(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fc_tcdm_port_serializer.sv
// Funnels N upstream TCDM master ports into a single XBAR port with round-robin
// arbitration and in-order response routing.
module fc_tcdm_port_serializer #(
    parameter int unsigned N_PORTS         = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [N_PORTS-1:0]                     in_req_i,
    output logic [N_PORTS-1:0]                     in_gnt_o,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]     in_add_i,
    input  logic [N_PORTS-1:0]                     in_wen_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]   in_be_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]     in_wdata_i,
    output logic [N_PORTS-1:0][DATA_WIDTH-1:0]     in_r_rdata_o,
    output logic [N_PORTS-1:0]                     in_r_valid_o,
    output logic                                   out_req_o,
    input  logic                                   out_gnt_i,
    output logic [ADDR_WIDTH-1:0]                  out_add_o,
    output logic                                   out_wen_o,
    output logic [DATA_WIDTH/8-1:0]                out_be_o,
    output logic [DATA_WIDTH-1:0]                  out_wdata_o,
    input  logic [DATA_WIDTH-1:0]                  out_r_rdata_i,
    input  logic                                   out_r_valid_i,
    output logic                                   err_o
);
    import fc_tcdm_pkg::*;

    localparam int unsigned IDX_W = idx_w(N_PORTS);

    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] head;
    logic             found;
    logic             full, empty;
    logic             hs, pop;
    logic             err_q, err_d;

    // Scan from rr_q upward with an explicit wrap so non-power-of-2 port counts work.
    always_comb begin
        int unsigned cand;
        logic [IDX_W-1:0] cand_idx;
        win      = rr_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= N_PORTS) begin
                cand = cand - N_PORTS;
            end
            cand_idx = IDX_W'(cand);
            if (!found && in_req_i[cand_idx]) begin
                found = 1'b1;
                win   = cand_idx;
            end
        end
    end

    assign out_req_o   = found && !full && !rst_i;
    assign hs          = out_req_o && out_gnt_i;
    assign pop         = out_r_valid_i && !empty && !rst_i;
    assign in_gnt_o    = hs ? (N_PORTS'(1) << win) : '0;
    assign in_r_valid_o = pop ? (N_PORTS'(1) << head) : '0;

    assign out_add_o   = in_add_i[win];
    assign out_wen_o   = in_wen_i[win];
    assign out_be_o    = in_be_i[win];
    assign out_wdata_o = in_wdata_i[win];

    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            in_r_rdata_o[i] = out_r_rdata_i;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (hs) begin
            rr_d = (win == IDX_W'(N_PORTS - 1)) ? '0 : win + 1'b1;
        end
        err_d = err_q || (out_r_valid_i && empty);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

    fc_tcdm_idx_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .data_i  (win),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule
